// File: rtl/cpu_store_buffer_pkg.sv
// Shared types and constants for the CPU store buffer.
package cpu_store_buffer_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [STRB_W-1:0] FULL_STRB = 4'b1111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    RESP  = ST_RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } entry_t;

endpackage

// File: rtl/cpu_store_buffer_if.sv
// CPU data port plus req/ack system bus seen by the store buffer.
interface cpu_store_buffer_if;
  import cpu_store_buffer_pkg::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [STRB_W-1:0] cpu_wenable;
  logic              cpu_read;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [STRB_W-1:0] bus_wstrb;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  // Store buffer side
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wenable, cpu_read, bus_ack, bus_rdata,
    output cpu_rdata, cpu_stall, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

  // CPU / bus-agent side
  modport master (
    output cpu_addr, cpu_wdata, cpu_wenable, cpu_read, bus_ack, bus_rdata,
    input  cpu_rdata, cpu_stall, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
  );

endinterface

// File: rtl/store_fifo.sv
// Circular store queue; with STORE_BUF_FWD_EN defined it also exposes a
// word-address search used for store-to-load forwarding.
module store_fifo
  import cpu_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output entry_t                 head,
  output entry_t                 second
`ifdef STORE_BUF_FWD_EN
  ,
  input  logic [ADDR_W-3:0]      search_word,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  assign head   = mem[rd_ptr];
  assign second = mem[rd_ptr + PTR_W'(1)];

`ifdef STORE_BUF_FWD_EN
  logic             found;
  logic             partial;
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    found    = 1'b0;
    partial  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (mem[idx].addr[ADDR_W-1:2] == search_word)) begin
        found    = 1'b1;
        fwd_data = mem[idx].wdata;
        if (mem[idx].wstrb != FULL_STRB) partial = 1'b1;
      end
    end
  end

  // Any partial overlap forces the drain-then-read path.
  assign fwd_hit = found && !partial;
`endif

endmodule

// File: rtl/cpu_store_buffer.sv
// Store buffer between the CPU memory stage and a req/ack data bus.
// Stores are queued and drained in the background; loads wait for the
// queue to drain. Optional macro STORE_BUF_FWD_EN adds full-word
// store-to-load forwarding from the queue.
module cpu_store_buffer
  import cpu_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  cpu_store_buffer_if.slave  sb
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_t            state;
  logic [CNT_W-1:0]  count;
  entry_t            head;
  entry_t            second;
  entry_t            push_entry;
  entry_t            next_entry;
  logic              store;
  logic              full;
  logic              pop;
  logic              push;
  logic              more_after_pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] rdata_q;

  assign store      = (sb.cpu_wenable != '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign pop        = (state == WRITE) && sb.bus_ack;
  assign push       = store && (!full || pop);
  assign push_entry = '{addr: sb.cpu_addr, wdata: sb.cpu_wdata, wstrb: sb.cpu_wenable};

  // Entry to present after a pop: the next queued one, or the store being
  // pushed this very edge when the queue held only the popped entry.
  assign more_after_pop = (count > CNT_W'(1)) || push;
  assign next_entry     = (count > CNT_W'(1)) ? second : push_entry;

`ifdef STORE_BUF_FWD_EN
  logic              fifo_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head),
    .second     (second)
`ifdef STORE_BUF_FWD_EN
    ,
    .search_word (sb.cpu_addr[ADDR_W-1:2]),
    .fwd_hit     (fifo_hit),
    .fwd_data    (fwd_data)
`endif
  );

`ifdef STORE_BUF_FWD_EN
  assign fwd_hit      = sb.cpu_read && !store && fifo_hit;
  assign sb.cpu_rdata = fwd_hit ? fwd_data : rdata_q;
`else
  assign fwd_hit      = 1'b0;
  assign sb.cpu_rdata = rdata_q;
`endif

  // Hold the CPU on a full queue (unless a pop frees a slot) or a pending load.
  assign sb.cpu_stall = (store && full && !pop) ||
                        (sb.cpu_read && (state != RESP) && !fwd_hit);

  // Bus sequencer: drain stores first, then issue at most one load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sb.bus_req   <= 1'b0;
      sb.bus_we    <= 1'b0;
      sb.bus_addr  <= '0;
      sb.bus_wdata <= '0;
      sb.bus_wstrb <= '0;
      rdata_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state        <= WRITE;
            sb.bus_req   <= 1'b1;
            sb.bus_we    <= 1'b1;
            sb.bus_addr  <= head.addr;
            sb.bus_wdata <= head.wdata;
            sb.bus_wstrb <= head.wstrb;
          end else if (sb.cpu_read && !store) begin
            state        <= READ;
            sb.bus_req   <= 1'b1;
            sb.bus_we    <= 1'b0;
            sb.bus_addr  <= sb.cpu_addr;
            sb.bus_wdata <= '0;
            sb.bus_wstrb <= '0;
          end
        end
        WRITE: begin
          if (sb.bus_ack) begin
            if (more_after_pop) begin
              sb.bus_addr  <= next_entry.addr;
              sb.bus_wdata <= next_entry.wdata;
              sb.bus_wstrb <= next_entry.wstrb;
            end else begin
              state      <= IDLE;
              sb.bus_req <= 1'b0;
              sb.bus_we  <= 1'b0;
            end
          end
        end
        READ: begin
          if (sb.bus_ack) begin
            state      <= RESP;
            sb.bus_req <= 1'b0;
            rdata_q    <= sb.bus_rdata;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          sb.bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_store_buffer.sv
// Directed bench for cpu_store_buffer (DEPTH=4) with a latency-programmable
// bus agent that logs every completed transfer.
module tb_cpu_store_buffer;

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    int          lat;
    int          exp_stall;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          cyc;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   ack_lat = 0;
  logic [31:0] rd_value = '0;
  int   proto_err = 0;
  int   req_hi = 0;
  txn_t log_q[$];

  cpu_store_buffer_if sb ();

  cpu_store_buffer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus agent: ack after ack_lat cycles of bus_req, one-cycle pulse.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    sb.bus_ack = 1'b0;
    sb.bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      sb.bus_ack = 1'b0;
      sb.bus_rdata = rd_value;
      if (!rst && sb.bus_req) begin
        if (wait_cnt >= ack_lat) begin
          sb.bus_ack = 1'b1;
          log_q.push_back('{we: sb.bus_we, addr: sb.bus_addr, wdata: sb.bus_wdata,
                            strb: sb.bus_wstrb, cyc: cyc});
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Load and store together is illegal CPU behaviour; count any occurrence.
  always @(negedge clk) begin
    if (sb.cpu_read && (sb.cpu_wenable != 4'h0)) proto_err++;
    if (sb.bus_req) req_hi++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int stalls);
    stalls = 0;
    sb.cpu_addr = a;
    sb.cpu_wdata = d;
    sb.cpu_wenable = s;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (!sb.cpu_stall) break;
      stalls++;
    end
    tick();
    sb.cpu_wenable = 4'h0;
  endtask

  task automatic cpu_load(input logic [31:0] a, output logic [31:0] d, output int stalls);
    stalls = 0;
    d = 'x;
    sb.cpu_addr = a;
    sb.cpu_read = 1'b1;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (!sb.cpu_stall) begin
        d = sb.cpu_rdata;
        break;
      end
      stalls++;
    end
    tick();
    sb.cpu_read = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    for (int g = 0; g < budget && log_q.size() < n; g++) tick();
    check32("log_size", 32'(log_q.size()), 32'(n));
  endtask

  initial begin
    vec_t        vecs[6];
    int          sc;
    int          n0;
    int          hi0;
    logic [31:0] d;
    int          exp_burst[6];

    vecs[0] = '{0, 32'h0000_0010, 32'h1122_3344, 4'hF, 32'h0, 0, 0};
    vecs[1] = '{0, 32'h0000_0014, 32'hA5A5_A5A5, 4'h3, 32'h0, 1, 0};
    vecs[2] = '{1, 32'h0000_0040, 32'h0,         4'h0, 32'h1234_5678, 0, 2};
    vecs[3] = '{1, 32'h0000_0044, 32'h0,         4'h0, 32'h0BAD_F00D, 2, 4};
    vecs[4] = '{0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h8, 32'h0, 0, 0};
    vecs[5] = '{1, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'hCAFE_BABE, 1, 3};
    exp_burst = '{0, 0, 0, 0, 1, 3};

    sb.cpu_addr = '0;
    sb.cpu_wdata = '0;
    sb.cpu_wenable = '0;
    sb.cpu_read = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_bus_req",   32'(sb.bus_req),   32'h0);
    check32("rst_bus_we",    32'(sb.bus_we),    32'h0);
    check32("rst_bus_addr",  sb.bus_addr,       32'h0);
    check32("rst_bus_wdata", sb.bus_wdata,      32'h0);
    check32("rst_bus_wstrb", 32'(sb.bus_wstrb), 32'h0);
    check32("rst_cpu_rdata", sb.cpu_rdata,      32'h0);
    check32("rst_cpu_stall", 32'(sb.cpu_stall), 32'h0);
    rst = 1'b0;
    tick();

    // Single transactions against an empty queue
    for (int v = 0; v < 6; v++) begin
      n0 = log_q.size();
      ack_lat = vecs[v].lat;
      rd_value = vecs[v].rdata;
      if (vecs[v].is_load) cpu_load(vecs[v].addr, d, sc);
      else cpu_store(vecs[v].addr, vecs[v].wdata, vecs[v].strb, sc);
      check32($sformatf("vec%0d_stall", v), 32'(sc), 32'(vecs[v].exp_stall));
      wait_log(n0 + 1, 50);
      if (log_q.size() > n0) begin
        check32($sformatf("vec%0d_we", v),   32'(log_q[n0].we), vecs[v].is_load ? 32'h0 : 32'h1);
        check32($sformatf("vec%0d_addr", v), log_q[n0].addr, vecs[v].addr);
        check32($sformatf("vec%0d_strb", v), 32'(log_q[n0].strb), 32'(vecs[v].strb));
        if (vecs[v].is_load) check32($sformatf("vec%0d_rdata", v), d, vecs[v].rdata);
        else check32($sformatf("vec%0d_wdata", v), log_q[n0].wdata, vecs[v].wdata);
      end
      tick();
    end

    // Burst of six stores into a 4-deep queue with slow acks
    n0 = log_q.size();
    ack_lat = 3;
    for (int k = 0; k < 6; k++) begin
      cpu_store(32'h0000_1000 + 32'(4 * k), 32'hB000_0000 + 32'(k), 4'hF, sc);
      check32($sformatf("burst%0d_stall", k), 32'(sc), 32'(exp_burst[k]));
    end
    wait_log(n0 + 6, 200);
    if (log_q.size() >= n0 + 6) begin
      for (int k = 0; k < 6; k++) begin
        check32($sformatf("burst%0d_addr", k), log_q[n0 + k].addr, 32'h0000_1000 + 32'(4 * k));
        check32($sformatf("burst%0d_data", k), log_q[n0 + k].wdata, 32'hB000_0000 + 32'(k));
        if (k > 0)
          check32($sformatf("burst%0d_gap", k),
                  32'(log_q[n0 + k].cyc - log_q[n0 + k - 1].cyc), 32'd4);
      end
    end
    tick();
    tick();

`ifdef STORE_BUF_FWD_EN
    // Full-word forward: load served from the queue, no bus read
    n0 = log_q.size();
    ack_lat = 3;
    cpu_store(32'h0000_0200, 32'hCAFE_F00D, 4'hF, sc);
    cpu_load(32'h0000_0200, d, sc);
    check32("fwd_stall", 32'(sc), 32'h0);
    check32("fwd_rdata", d, 32'hCAFE_F00D);
    wait_log(n0 + 1, 50);
    repeat (6) tick();
    check32("fwd_no_bus_read", 32'(log_q.size()), 32'(n0 + 1));
    // Partial overlap: drain then read
    n0 = log_q.size();
    ack_lat = 1;
    rd_value = 32'h600D_D00D;
    cpu_store(32'h0000_0200, 32'h1111_1111, 4'hF, sc);
    cpu_store(32'h0000_0201, 32'h0000_AB00, 4'h2, sc);
    cpu_load(32'h0000_0200, d, sc);
    check32("part_stalled", 32'(sc > 0), 32'h1);
    check32("part_rdata", d, 32'h600D_D00D);
    wait_log(n0 + 3, 50);
    if (log_q.size() >= n0 + 3) begin
      check32("part_wr2_addr", log_q[n0 + 1].addr, 32'h0000_0201);
      check32("part_rd_we", 32'(log_q[n0 + 2].we), 32'h0);
      check32("part_rd_addr", log_q[n0 + 2].addr, 32'h0000_0200);
    end
    tick();
`else
    // Load behind a queued store to the same address waits for the drain
    n0 = log_q.size();
    ack_lat = 1;
    rd_value = 32'h5A5A_0100;
    cpu_store(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, sc);
    cpu_load(32'h0000_0100, d, sc);
    check32("order_stall", 32'(sc), 32'd6);
    check32("order_rdata", d, 32'h5A5A_0100);
    wait_log(n0 + 2, 50);
    if (log_q.size() >= n0 + 2) begin
      check32("order_wr_we", 32'(log_q[n0].we), 32'h1);
      check32("order_wr_data", log_q[n0].wdata, 32'hDEAD_BEEF);
      check32("order_rd_we", 32'(log_q[n0 + 1].we), 32'h0);
      check32("order_rd_addr", log_q[n0 + 1].addr, 32'h0000_0100);
    end
    tick();
`endif

    // Reset in the middle of a write with three stores queued
    ack_lat = 40;
    for (int k = 0; k < 3; k++) cpu_store(32'h0000_2000 + 32'(4 * k), 32'(k), 4'hF, sc);
    tick();
    check32("pre_rst_req", 32'(sb.bus_req), 32'h1);
    rst = 1'b1;
    #1;
    check32("rst_mid_req", 32'(sb.bus_req), 32'h0);
    check32("rst_mid_stall", 32'(sb.cpu_stall), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ack_lat = 0;
    n0 = log_q.size();
    hi0 = req_hi;
    repeat (8) tick();
    check32("post_rst_idle_bus", 32'(req_hi - hi0), 32'h0);
    check32("post_rst_no_txn", 32'(log_q.size()), 32'(n0));
    rd_value = 32'h0000_0077;
    cpu_load(32'h0000_0300, d, sc);
    check32("post_rst_load_stall", 32'(sc), 32'd2);
    check32("post_rst_load_rdata", d, 32'h0000_0077);
    tick();

    check32("protocol_clean", 32'(proto_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cpu_store_buffer.md
Name: cpu_store_buffer

Overview:
Sits directly downstream of the pipelined CPU's memory stage, between the CPU data port and a req/ack system data bus.
- Stores are queued in a small FIFO and drained to the bus in the background, so the CPU does not wait on stores.
- Loads are strictly ordered behind all older queued stores.
- cpu_stall freezes the CPU pipeline while a load is outstanding or the queue is full.

Parameters:
DEPTH, 4, number of store entries; power of two, minimum 2.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
cpu_addr  in  32  byte address from the CPU memory stage (held stable while cpu_stall=1)
cpu_wdata  in  32  store data, already lane-aligned
cpu_wenable  in  4  byte-lane write strobes; nonzero marks a store
cpu_read  in  1  load request (mutually exclusive with nonzero cpu_wenable)
cpu_rdata  out  32  load data, valid in the cycle cpu_stall falls for a load
cpu_stall  out  1  CPU must hold its memory-stage request
bus_req  out  1  bus transfer request
bus_we  out  1  1 = write, 0 = read
bus_addr  out  32  bus address
bus_wdata  out  32  bus write data
bus_wstrb  out  4  bus byte strobes
bus_ack  in  1  one-cycle transfer completion
bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
Reset (async, active-high):
- FIFO is emptied (count=0, pointers=0) and the FSM goes to IDLE.
- Outputs: bus_req=0, bus_we=0, bus_addr/wdata/wstrb=0, cpu_rdata=0, cpu_stall=0.
- Reset mid-transfer drops bus_req immediately; queued stores are discarded.

FIFO:
- Entry = {addr[31:0], wdata[31:0], wstrb[3:0]}; count is ceil(log2(DEPTH))+1 bits; pointers wrap modulo DEPTH.
- A store (cpu_wenable!=0) with count<DEPTH is enqueued at the clock edge, and cpu_stall=0 for it.
- A store arriving when count==DEPTH gives cpu_stall=1 combinationally.
  - In the cycle a pop occurs (bus_ack in WRITE), the full condition is released combinationally and the store is enqueued at that same edge.
  - Simultaneous push and pop leaves count unchanged.

FSM states: IDLE, WRITE, READ, RESP.
- IDLE: if count>0, go to WRITE and present the head entry. Otherwise, if cpu_read, go to READ with bus_addr=cpu_addr.
- WRITE:
  - bus_req=1, bus_we=1; payload stays stable until bus_ack.
  - On bus_ack, pop the head. If the new count>0, stay in WRITE with the next entry and no idle cycle. Otherwise go to IDLE.
- READ:
  - bus_req=1, bus_we=0, bus_wstrb=0.
  - On bus_ack, capture bus_rdata into cpu_rdata and go to RESP.
- RESP: cpu_stall=0 for this cycle (the CPU consumes cpu_rdata), then go to IDLE.
  - cpu_rdata holds its value until the next load capture.

Stall and bus rules:
- cpu_stall = (store && count==DEPTH && !pop) || (cpu_read && state!=RESP).
- Ordering: a load never reaches the bus while count>0.
- bus_req is deasserted only after bus_ack, never withdrawn early.
- Store and load asserted together: protocol violation; the store takes priority; the bench flags it.
- Minimum load latency with an empty queue is 3 cycles (IDLE→READ, ack, RESP), given bus_ack in the first READ cycle.

Optional Feature:
Macro STORE_BUF_FWD_EN.
- Defined: on a load, the FIFO is searched for entries with addr[31:2]==cpu_addr[31:2].
  - If the youngest such entry has wstrb==4'b1111, cpu_rdata is driven combinationally from its wdata and cpu_stall=0 in that same cycle.
  - FSM and bus are unaffected, and draining continues in the background.
  - If any matching entry is partial, or there is no match while count>0, the normal drain-then-read path is used.
- Undefined: no search logic; every load takes the drain-then-read path.

Decomposition:
- Package cpu_store_buffer_pkg holds:
  - FSM state encoding (2-bit localparams for IDLE/WRITE/READ/RESP);
  - entry field widths and the full-word strobe constant 4'b1111.
- One sub-module, store_fifo: synchronous FIFO with push/pop/count/head outputs, plus a match-search port compiled under STORE_BUF_FWD_EN.

Test Plan:
- Reset: assert rst mid-WRITE with 3 entries queued → bus_req=0 in the same cycle; after release, count=0, cpu_stall=0, no bus activity.
- Burst of 5 stores, DEPTH=4, bus_ack delayed 3 cycles each → stall only on the 5th store until the first ack; bus sees addresses in order with no idle cycles between writes.
- Store 0x100=0xDEADBEEF, then load 0x100 with fwd off → load issued only after the write ack; cpu_rdata=bus_rdata in the RESP cycle.
- Load with empty queue, bus_ack after 1 cycle → cpu_stall high exactly 2 cycles, cpu_rdata=0x12345678 when stall falls.
- STORE_BUF_FWD_EN: store 0x200=0xCAFEF00D (wstrb=F), load 0x200 → cpu_rdata=0xCAFEF00D, cpu_stall=0, no bus read. Repeat after a byte store to 0x201 → drain path taken.
- Full queue, stall released by the pop edge → the new store is accepted at the same edge as the pop; count stays at 4.
